// File: rtl/gpio_apb_arb_pkg.sv
// Shared FSM state type, default bus widths and requester limits for the GPIO APB arbiter.
package gpio_apb_arb_pkg;

    localparam int AW_DEFAULT = 8;
    localparam int DW_DEFAULT = 32;
    localparam int NREQ_MAX   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Width of a requester index; at least one bit so that degenerate builds still elaborate.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping modulo NREQ.
module gpio_rr_arbiter
    import gpio_apb_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   grant_idx_o
);

    int            sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path leaves a latch.
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = 0;
        idx         = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = int'(ptr_i) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = PW'(sum);
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Round-robin sharing of one APB3 slave port among NREQ valid/ready requesters.
// Optional ACCESS timeout enabled by defining GPIO_APB_ARB_TIMEOUT_EN.
module gpio_apb_arbiter
    import gpio_apb_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ-1:0]  req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic [AW-1:0]    PADDR,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [DW-1:0]    PWDATA,
    input  logic [DW-1:0]    PRDATA,
    input  logic             PREADY,
    input  logic             PSLVERR
);

    localparam int PW = ptr_width(NREQ);

    apb_state_e       state_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [NREQ-1:0]  owner_q;
    logic [AW-1:0]    paddr_q;
    logic             pwrite_q;
    logic [DW-1:0]    pwdata_q;
    logic             psel_q;
    logic             penable_q;
    logic [NREQ-1:0]  rsp_valid_q;
    logic [DW-1:0]    rsp_rdata_q;
    logic             rsp_err_q;

    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    grant_idx;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             sel_write;
    logic             timeout_hit;

    gpio_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    always_comb begin
        sel_addr  = req_addr[int'(grant_idx)*AW +: AW];
        sel_wdata = req_wdata[int'(grant_idx)*DW +: DW];
        sel_write = req_write[grant_idx];
        ptr_d     = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end

    // The accept strobe is combinational in IDLE; it is forced low while reset is held.
    assign req_ready = (state_q == IDLE && !PRESET) ? grant : '0;

`ifdef GPIO_APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Hitting TIMEOUT-1 here means this ACCESS cycle is the TIMEOUT-th one.
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        owner_q   <= grant;
                        ptr_q     <= ptr_d;
                        paddr_q   <= sel_addr;
                        pwrite_q  <= sel_write;
                        pwdata_q  <= sel_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A completing PREADY takes priority over an expiring timeout.
                    if (PREADY) begin
                        rsp_valid_q <= owner_q;
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q   <= PSLVERR;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= IDLE;
                    end else if (timeout_hit) begin
                        rsp_valid_q <= owner_q;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Self-checking bench for gpio_apb_arbiter: directed vector table, corner sequences and a randomized model run.
module tb_gpio_apb_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int TO   = 4;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [NREQ-1:0]   req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata, PWDATA, PRDATA;
    logic              rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0]     PADDR;

    int checks = 0;
    int errors = 0;

    gpio_apb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int             req;
        logic           wr;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [DW-1:0]  prdata;
        int             waits;
        logic           slverr;
        logic [DW-1:0]  exp_rdata;
        logic           exp_err;
        string          name;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge (drive phase).
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        PRESET    = 1'b1;
        req_valid = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        tick();
        tick();
        PRESET = 1'b0;
    endtask

    // One isolated transfer from a table entry; starts and ends in a drive phase where a grant is possible.
    task automatic xfer(input vec_t v);
        req_valid = '0;
        set_req(v.req, 1'b1, v.wr, v.addr, v.wdata);
        PREADY = 1'b0; PSLVERR = 1'b0;
        #1;
        check({v.name, "_ready"}, req_ready, 64'(1) << v.req);
        check({v.name, "_idle_psel"}, PSEL, 0);
        tick();
        req_valid = '0;
        #1;
        check({v.name, "_setup"}, {PSEL, PENABLE}, 2'b10);
        check({v.name, "_paddr"}, PADDR, v.addr);
        check({v.name, "_pwrite"}, PWRITE, v.wr);
        for (int w = 0; w <= v.waits; w++) begin
            tick();
            PREADY  = (w == v.waits);
            PRDATA  = v.prdata;
            PSLVERR = v.slverr;
            #1;
            check({v.name, "_access"}, {PSEL, PENABLE}, 2'b11);
            check({v.name, "_hold_addr"}, PADDR, v.addr);
            if (v.wr) check({v.name, "_pwdata"}, PWDATA, v.wdata);
            check({v.name, "_no_early_rsp"}, rsp_valid, 0);
        end
        tick();
        PREADY = 1'b0; PSLVERR = 1'b0;
        #1;
        check({v.name, "_rsp_valid"}, rsp_valid, 64'(1) << v.req);
        check({v.name, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({v.name, "_rsp_err"}, rsp_err, v.exp_err);
        check({v.name, "_rsp_idle"}, {PSEL, PENABLE}, 2'b00);
    endtask

    // Randomized run checked against a transaction-level model of the arbitration rules.
    task automatic random_run(input int cycles);
        bit            pend[NREQ];
        logic          rw[NREQ];
        logic [AW-1:0] ra[NREQ];
        logic [DW-1:0] rd[NREQ];
        int            next_pick, win, age, rsp_who, g;
        bit            active, rsp_due, exp_err;
        logic          cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd, exp_rd;
        next_pick = 0; active = 0; rsp_due = 0; age = 0; win = 0; rsp_who = 0;
        exp_err = 0; exp_rd = '0; cw = 0; ca = '0; cd = '0;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    rw[i] = 1'($urandom_range(0, 1));
                    ra[i] = AW'($urandom);
                    rd[i] = $urandom;
                end
                set_req(i, pend[i], rw[i], ra[i], rd[i]);
            end
            PREADY  = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            PSLVERR = ($urandom_range(0, 7) == 0);
            #1;
            if (rsp_due) begin
                check("rnd_rsp_valid", rsp_valid, 64'(1) << rsp_who);
                check("rnd_rsp_rdata", rsp_rdata, exp_rd);
                check("rnd_rsp_err", rsp_err, exp_err);
            end else begin
                check("rnd_no_rsp", rsp_valid, 0);
            end
            rsp_due = 0;
            if (active) begin
                check("rnd_busy_ready", req_ready, 0);
                check("rnd_psel", PSEL, 1);
                check("rnd_penable", PENABLE, (age >= 2));
                check("rnd_paddr", PADDR, ca);
                check("rnd_pwrite", PWRITE, cw);
                if (cw) check("rnd_pwdata", PWDATA, cd);
                if (age >= 2 && PREADY) begin
                    rsp_due = 1; rsp_who = win;
                    exp_rd  = cw ? '0 : PRDATA;
                    exp_err = PSLVERR;
                    active  = 0;
                end else begin
                    age++;
                end
            end else begin
                check("rnd_idle_apb", {PSEL, PENABLE}, 2'b00);
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && pend[(next_pick + k) % NREQ]) g = (next_pick + k) % NREQ;
                end
                if (g >= 0) begin
                    check("rnd_grant", req_ready, 64'(1) << g);
                    active = 1; age = 1; win = g;
                    cw = rw[g]; ca = ra[g]; cd = rd[g];
                    pend[g] = 0;
                    next_pick = (g + 1) % NREQ;
                end else begin
                    check("rnd_no_grant", req_ready, 0);
                end
            end
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{0, 1'b1, 8'h08, 32'hA5A5_0001, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,         1'b0, "wr_single"};
        vecs[1] = '{1, 1'b0, 8'h80, 32'h0,         32'h0012_3456, 5, 1'b0, 32'h0012_3456, 1'b0, "rd_wait5"};
        vecs[2] = '{0, 1'b0, 8'h44, 32'h0,         32'h1111_2222, 0, 1'b1, 32'h1111_2222, 1'b1, "rd_slverr"};
        vecs[3] = '{1, 1'b0, 8'h48, 32'h0,         32'h3333_4444, 1, 1'b0, 32'h3333_4444, 1'b0, "rd_after_err"};
        vecs[4] = '{1, 1'b1, 8'hFC, 32'h0BAD_F00D, 32'h5555_6666, 2, 1'b1, 32'h0,         1'b1, "wr_slverr"};
        vecs[5] = '{0, 1'b0, 8'h00, 32'h0,         32'hFFFF_FFFF, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, "rd_ones"};

        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRESET = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        tick();
        req_valid = 2'b11;
        #1;
        check("reset_ready", req_ready, 0);
        check("reset_apb", {PSEL, PENABLE, PWRITE}, 3'b000);
        check("reset_paddr", PADDR, 0);
        check("reset_rsp", {rsp_valid, rsp_err}, 0);
        check("reset_rdata", rsp_rdata, 0);
        do_reset();

        for (int i = 0; i < 6; i++) xfer(vecs[i]);

        // Both requesters continuously valid: grants must alternate starting at requester 0.
        do_reset();
        set_req(0, 1'b1, 1'b0, 8'h10, '0);
        set_req(1, 1'b1, 1'b0, 8'h20, '0);
        for (int t = 0; t < 4; t++) begin
            logic [AW-1:0] ea;
            int            g;
            g  = t % 2;
            ea = (g == 1) ? 8'h20 : 8'h10;
            #1;
            check("rr_grant", req_ready, 64'(1) << g);
            tick();
            #1;
            check("rr_paddr", PADDR, ea);
            tick();
            PREADY = 1'b1;
            PRDATA = 32'h5000_0000 | 32'(ea);
            #1;
            check("rr_access", {PSEL, PENABLE}, 2'b11);
            tick();
            PREADY = 1'b0;
            #1;
            check("rr_rsp_valid", rsp_valid, 64'(1) << g);
            check("rr_rsp_rdata", rsp_rdata, 32'h5000_0000 | 32'(ea));
        end

        // Reset during ACCESS after requester 0 won: APB drops at once, no response, requester 0 wins again.
        do_reset();
        set_req(0, 1'b1, 1'b1, 8'h33, 32'h0000_1234);
        #1;
        check("mid_rst_accept", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        PREADY = 1'b0;
        #1;
        check("mid_rst_in_access", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        #1;
        check("mid_rst_async_drop", {PSEL, PENABLE}, 2'b00);
        tick();
        set_req(0, 1'b1, 1'b0, 8'h01, '0);
        set_req(1, 1'b1, 1'b0, 8'h02, '0);
        #1;
        check("mid_rst_held_ready", req_ready, 0);
        PRESET = 1'b0;
        #1;
        check("mid_rst_first_winner", req_ready, 2'b01);
        check("mid_rst_no_rsp", rsp_valid, 0);
        tick();
        req_valid = 2'b10;
        #1;
        check("mid_rst_no_rsp_after", rsp_valid, 0);
        check("mid_rst_new_setup", {PSEL, PENABLE}, 2'b10);
        check("mid_rst_new_addr", PADDR, 8'h01);

`ifdef GPIO_APB_ARB_TIMEOUT_EN
        do_reset();
        set_req(0, 1'b1, 1'b0, 8'h55, '0);
        PRDATA = 32'hCAFE_CAFE;
        #1;
        check("to_accept", req_ready, 2'b01);
        tick();
        req_valid = '0;
        for (int k = 0; k < TO; k++) begin
            tick();
            #1;
            check("to_access", {PSEL, PENABLE}, 2'b11);
            check("to_no_rsp", rsp_valid, 0);
        end
        tick();
        #1;
        check("to_abort_apb", {PSEL, PENABLE}, 2'b00);
        check("to_rsp_valid", rsp_valid, 2'b01);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
`endif

        do_reset();
        random_run(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
